// File: rtl/prog_counter.sv
// prog_counter: parametrised registered up/down event counter.
// Counts over 0..MAX_VAL. At the bounds it either wraps or saturates.
// A prescaler divides the enable down to count steps.
// Outputs are a one-cycle terminal-count pulse and a sticky overflow flag.
// Priority in any cycle is clr > load > step.
module prog_counter #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter bit               SATURATE = 1'b0,
   parameter int               PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   // The prescaler needs at least one bit, even when PRESCALE is 1 and it never leaves 0.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PSC_LAST  = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PSC_ONE   = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ZERO  = '0;

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    psc_q, psc_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;

   logic             step;
   logic             at_max;
   logic             at_zero;

   // A step happens on the enabled cycle that completes a prescaler period.
   assign step    = en && (psc_q == PSC_LAST);
   assign at_max  = (count_q == MAX_VAL);
   assign at_zero = (count_q == CNT_ZERO);

   // Next-state logic: clear, then load (clamped to MAX_VAL), then prescaled step.
   always_comb begin
      count_d = count_q;
      psc_d   = psc_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = CNT_ZERO;
         psc_d   = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         psc_d   = '0;
      end else if (en) begin
         if (step) begin
            psc_d = '0;
            if (up_dn) begin
               if (at_max) begin
                  // Boundary step: wrap to 0 or hold at MAX_VAL, pulse tc in both modes
                  count_d = SATURATE ? MAX_VAL : CNT_ZERO;
                  tc_d    = 1'b1;
                  ovf_d   = 1'b1;
               end else begin
                  count_d = count_q + CNT_ONE;
               end
            end else begin
               if (at_zero) begin
                  count_d = SATURATE ? CNT_ZERO : MAX_VAL;
                  tc_d    = 1'b1;
                  ovf_d   = 1'b1;
               end else begin
                  count_d = count_q - CNT_ONE;
               end
            end
         end else begin
            psc_d = psc_q + PSC_ONE;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= CNT_ZERO;
         psc_q   <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         psc_q   <= psc_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: four counter configurations share clk and rst_n.
// Each configuration has its own stimulus.
//   u0: WIDTH=16 defaults
//   u1: WIDTH=4, MAX_VAL=9, wrap mode
//   u2: WIDTH=8, MAX_VAL=200, saturate mode
//   u3: WIDTH=8, PRESCALE=4
// An arithmetic model tracks all four. A negedge compare process checks every cycle.
// Directed literal checks pin the model.
module tb_prog_counter;

   logic clk;
   logic rst_n;

   logic en_s[4];
   logic up_s[4];
   logic clr_s[4];
   logic load_s[4];

   logic [15:0] lv0;
   logic [3:0]  lv1;
   logic [7:0]  lv2;
   logic [7:0]  lv3;

   logic [15:0] cnt0;
   logic [3:0]  cnt1;
   logic [7:0]  cnt2;
   logic [7:0]  cnt3;
   logic        tc_o[4];
   logic        ovf_o[4];

   int total;
   int bad;

   // Configuration table mirrored from the instance parameters
   int max_of[4] = '{65535, 9, 200, 255};
   int sat_of[4] = '{0, 0, 1, 0};
   int ps_of[4]  = '{1, 1, 1, 4};

   // Model state
   int m_cnt[4];
   int m_psc[4];
   int m_tc[4];
   int m_ovf[4];

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   prog_counter #(.WIDTH(16)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en_s[0]), .up_dn(up_s[0]), .clr(clr_s[0]),
      .load(load_s[0]), .load_val(lv0), .count(cnt0), .tc(tc_o[0]), .ovf(ovf_o[0])
   );
   prog_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en_s[1]), .up_dn(up_s[1]), .clr(clr_s[1]),
      .load(load_s[1]), .load_val(lv1), .count(cnt1), .tc(tc_o[1]), .ovf(ovf_o[1])
   );
   prog_counter #(.WIDTH(8), .MAX_VAL(8'd200), .SATURATE(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en_s[2]), .up_dn(up_s[2]), .clr(clr_s[2]),
      .load(load_s[2]), .load_val(lv2), .count(cnt2), .tc(tc_o[2]), .ovf(ovf_o[2])
   );
   prog_counter #(.WIDTH(8), .PRESCALE(4)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en_s[3]), .up_dn(up_s[3]), .clr(clr_s[3]),
      .load(load_s[3]), .load_val(lv3), .count(cnt3), .tc(tc_o[3]), .ovf(ovf_o[3])
   );

   function automatic int lv_of(input int i);
      case (i)
         0: return int'(lv0);
         1: return int'(lv1);
         2: return int'(lv2);
         default: return int'(lv3);
      endcase
   endfunction

   function automatic int cnt_of(input int i);
      case (i)
         0: return int'(cnt0);
         1: return int'(cnt1);
         2: return int'(cnt2);
         default: return int'(cnt3);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one count step per PRESCALE enabled cycles, on the range 0..max.
   task automatic model_cycle(input int i);
      int lv;
      lv = lv_of(i);
      m_tc[i] = 0;
      if (clr_s[i]) begin
         m_cnt[i] = 0;
         m_psc[i] = 0;
         m_ovf[i] = 0;
      end else if (load_s[i]) begin
         m_cnt[i] = (lv > max_of[i]) ? max_of[i] : lv;
         m_psc[i] = 0;
      end else if (en_s[i]) begin
         m_psc[i] = m_psc[i] + 1;
         if (m_psc[i] == ps_of[i]) begin
            m_psc[i] = 0;
            if (up_s[i]) begin
               if (m_cnt[i] == max_of[i]) begin
                  m_tc[i] = 1;
                  m_ovf[i] = 1;
                  m_cnt[i] = sat_of[i] ? max_of[i] : 0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end else begin
               if (m_cnt[i] == 0) begin
                  m_tc[i] = 1;
                  m_ovf[i] = 1;
                  m_cnt[i] = sat_of[i] ? 0 : max_of[i];
               end else begin
                  m_cnt[i] = m_cnt[i] - 1;
               end
            end
         end
      end
   endtask

   // Model update on each clock edge, cleared asynchronously with the DUTs
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_psc[i] = 0;
            m_tc[i]  = 0;
            m_ovf[i] = 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) model_cycle(i);
      end
   end

   // Scoreboard compare on every falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         check($sformatf("u%0d_count", i), cnt_of(i), m_cnt[i]);
         check($sformatf("u%0d_tc", i), int'(tc_o[i]), m_tc[i]);
         check($sformatf("u%0d_ovf", i), int'(ovf_o[i]), m_ovf[i]);
      end
   end

   // Driver helpers: inputs change just after a falling edge
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed stimulus with literal expectations
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en_s[i]   = 1'b0;
         up_s[i]   = 1'b1;
         clr_s[i]  = 1'b0;
         load_s[i] = 1'b0;
      end
      lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;

      // Reset held for three clocks
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_count", int'(cnt0), 0);
      end
      rst_n = 1'b1;

      // Free-run: 256 enabled cycles
      en_s[0] = 1'b1;
      cycles(256);
      check("free_run_count", int'(cnt0), 256);
      check("free_run_tc", int'(tc_o[0]), 0);
      check("free_run_ovf", int'(ovf_o[0]), 0);
      en_s[0] = 1'b0;

      // Wrap at MAX_VAL=9
      en_s[1] = 1'b1;
      cycles(9);
      check("wrap_at_9", int'(cnt1), 9);
      check("wrap_tc_before", int'(tc_o[1]), 0);
      cycles(1);
      check("wrap_count", int'(cnt1), 0);
      check("wrap_tc", int'(tc_o[1]), 1);
      check("wrap_ovf", int'(ovf_o[1]), 1);
      en_s[1] = 1'b0;
      cycles(1);
      check("wrap_tc_one_cycle", int'(tc_o[1]), 0);
      check("wrap_ovf_sticky", int'(ovf_o[1]), 1);
      clr_s[1] = 1'b1;
      cycles(1);
      clr_s[1] = 1'b0;
      check("clr_count", int'(cnt1), 0);
      check("clr_ovf", int'(ovf_o[1]), 0);
      // Down-step from 0 wraps to MAX_VAL
      up_s[1] = 1'b0;
      en_s[1] = 1'b1;
      cycles(1);
      en_s[1] = 1'b0;
      check("down_wrap_count", int'(cnt1), 9);
      check("down_wrap_tc", int'(tc_o[1]), 1);

      // Saturate down from 2: 1, 0, 0, 0
      load_s[2] = 1'b1;
      lv2 = 8'd2;
      cycles(1);
      load_s[2] = 1'b0;
      check("sat_load", int'(cnt2), 2);
      up_s[2] = 1'b0;
      en_s[2] = 1'b1;
      cycles(1);
      check("sat_step1", int'(cnt2), 1);
      check("sat_step1_tc", int'(tc_o[2]), 0);
      cycles(1);
      check("sat_step2", int'(cnt2), 0);
      check("sat_step2_tc", int'(tc_o[2]), 0);
      cycles(1);
      check("sat_step3", int'(cnt2), 0);
      check("sat_step3_tc", int'(tc_o[2]), 1);
      cycles(1);
      check("sat_step4", int'(cnt2), 0);
      check("sat_step4_tc", int'(tc_o[2]), 1);
      check("sat_ovf", int'(ovf_o[2]), 1);
      en_s[2] = 1'b0;
      cycles(1);
      check("sat_tc_drop", int'(tc_o[2]), 0);

      // Priority: clr beats load and step
      clr_s[2] = 1'b1;
      load_s[2] = 1'b1;
      en_s[2] = 1'b1;
      lv2 = 8'd77;
      cycles(1);
      clr_s[2] = 1'b0;
      en_s[2] = 1'b0;
      check("prio_clr_count", int'(cnt2), 0);
      check("prio_clr_ovf", int'(ovf_o[2]), 0);
      // Load clamps to MAX_VAL
      lv2 = 8'd250;
      cycles(1);
      check("load_clamp", int'(cnt2), 200);
      // Load with enable: no step
      lv2 = 8'd5;
      en_s[2] = 1'b1;
      up_s[2] = 1'b1;
      cycles(1);
      load_s[2] = 1'b0;
      en_s[2] = 1'b0;
      check("load_beats_step", int'(cnt2), 5);
      cycles(1);
      check("load_no_late_step", int'(cnt2), 5);
      // Saturate up at 200
      load_s[2] = 1'b1;
      lv2 = 8'd199;
      cycles(1);
      load_s[2] = 1'b0;
      en_s[2] = 1'b1;
      cycles(1);
      check("sat_up_200", int'(cnt2), 200);
      check("sat_up_tc0", int'(tc_o[2]), 0);
      cycles(1);
      en_s[2] = 1'b0;
      check("sat_up_hold", int'(cnt2), 200);
      check("sat_up_tc1", int'(tc_o[2]), 1);

      // Prescaler: en pattern 1,1,0,1,1
      en_s[3] = 1'b1;
      cycles(1);
      check("psc_c1", int'(cnt3), 0);
      cycles(1);
      check("psc_c2", int'(cnt3), 0);
      en_s[3] = 1'b0;
      cycles(1);
      check("psc_c3_hold", int'(cnt3), 0);
      en_s[3] = 1'b1;
      cycles(1);
      check("psc_c4", int'(cnt3), 0);
      cycles(1);
      check("psc_step", int'(cnt3), 1);
      cycles(4);
      en_s[3] = 1'b0;
      check("psc_step2", int'(cnt3), 2);

      // Async reset between clock edges at count 37
      load_s[0] = 1'b1;
      lv0 = 16'd37;
      cycles(1);
      load_s[0] = 1'b0;
      check("pre_rst_count", int'(cnt0), 37);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_count", int'(cnt0), 0);
      check("async_rst_tc", int'(tc_o[0]), 0);
      check("async_rst_ovf", int'(ovf_o[0]), 0);
      check("async_rst_u2_ovf", int'(ovf_o[2]), 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
